// File: rtl/sdram_rd_port_client.sv
// Read-port requester: wins an arbiter slot, then issues one single-word read per
// index and streams each returned word downstream with its index.
module sdram_rd_port_client #(
  parameter int unsigned LEN_W     = 11,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             iStart,
  input  logic [23:0]      iBase_Addr,
  input  logic [LEN_W-1:0] iLen,
  output logic             oSched_Req,
  input  logic             iSched_Ack,
  output logic             oSched_Done,
  output logic             oRd_Req,
  output logic [23:0]      oRd_Addr,
  input  logic             iRd_Done,
  input  logic [15:0]      iRd_Data,
  output logic             oData_Valid,
  output logic [15:0]      oData,
  output logic [LEN_W-1:0] oData_Idx,
  output logic             oBusy,
  output logic             oDone
);

  typedef enum logic [2:0] {IDLE, REQ, RD, GAP, REL} state_t;

  state_t           state, stateNxt;
  logic [23:0]      addr, addrNxt;
  logic [LEN_W-1:0] len, lenNxt;
  logic [LEN_W-1:0] idx, idxNxt;
  logic             schedReqNxt, schedDoneNxt, rdReqNxt, validNxt, doneNxt;
  logic [15:0]      dataNxt;
  logic [LEN_W-1:0] dataIdxNxt;
  logic             lastWord;

  assign lastWord = (idx == len - LEN_W'(1));
  assign oRd_Addr = addr;
  assign oBusy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      len         <= '0;
      idx         <= '0;
      oSched_Req  <= 1'b0;
      oSched_Done <= 1'b0;
      oRd_Req     <= 1'b0;
      oData_Valid <= 1'b0;
      oData       <= '0;
      oData_Idx   <= '0;
      oDone       <= 1'b0;
    end else if (en) begin
      state       <= stateNxt;
      addr        <= addrNxt;
      len         <= lenNxt;
      idx         <= idxNxt;
      oSched_Req  <= schedReqNxt;
      oSched_Done <= schedDoneNxt;
      oRd_Req     <= rdReqNxt;
      oData_Valid <= validNxt;
      oData       <= dataNxt;
      oData_Idx   <= dataIdxNxt;
      oDone       <= doneNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (iStart && (iLen != '0)) stateNxt = REQ;
      REQ:     if (iSched_Ack) stateNxt = RD;
      RD:      if (iRd_Done) stateNxt = lastWord ? REL : GAP;
      GAP:     stateNxt = RD;
      REL:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Outputs are registered; REL raises the release pulses for the cycle after it,
  // which places oDone one cycle behind the last oData_Valid.
  always_comb begin
    addrNxt      = addr;
    lenNxt       = len;
    idxNxt       = idx;
    schedReqNxt  = oSched_Req;
    rdReqNxt     = oRd_Req;
    dataNxt      = oData;
    dataIdxNxt   = oData_Idx;
    schedDoneNxt = 1'b0;
    validNxt     = 1'b0;
    doneNxt      = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          if (iLen != '0) begin
            addrNxt     = iBase_Addr;
            lenNxt      = iLen;
            idxNxt      = '0;
            schedReqNxt = 1'b1;
          end else begin
            doneNxt = 1'b1;
          end
        end
      end
      REQ: begin
        if (iSched_Ack) begin
          schedReqNxt = 1'b0;
          rdReqNxt    = 1'b1;
        end
      end
      RD: begin
        if (iRd_Done) begin
          dataNxt    = iRd_Data;
          dataIdxNxt = idx;
          validNxt   = 1'b1;
          rdReqNxt   = 1'b0;
          addrNxt    = addr + 24'(ADDR_STEP);
          idxNxt     = idx + LEN_W'(1);
        end
      end
      GAP: rdReqNxt = 1'b1;
      REL: begin
        schedDoneNxt = 1'b1;
        doneNxt      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_rd_port_client.sv
// Scoreboard bench for sdram_rd_port_client: responders model the arbiter and the
// SDRAM glue, a negedge monitor pops expected words as oData_Valid is consumed.
module tb_sdram_rd_port_client;

  logic        clk = 1'b0;
  logic        rst_n, en, iStart;
  logic [23:0] iBase_Addr;
  logic [10:0] iLen;
  logic        oSched_Req, iSched_Ack, oSched_Done, oRd_Req, iRd_Done;
  logic [23:0] oRd_Addr;
  logic [15:0] iRd_Data, oData;
  logic        oData_Valid, oBusy, oDone;
  logic [10:0] oData_Idx;

  sdram_rd_port_client #(.LEN_W(11), .ADDR_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .iStart(iStart),
    .iBase_Addr(iBase_Addr), .iLen(iLen),
    .oSched_Req(oSched_Req), .iSched_Ack(iSched_Ack), .oSched_Done(oSched_Done),
    .oRd_Req(oRd_Req), .oRd_Addr(oRd_Addr), .iRd_Done(iRd_Done), .iRd_Data(iRd_Data),
    .oData_Valid(oData_Valid), .oData(oData), .oData_Idx(oData_Idx),
    .oBusy(oBusy), .oDone(oDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic [10:0] idx;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0, fails = 0;
  int   ackDelay = 0, rdDelay = 0, reqCnt = 0, rdCnt = 0;
  bit   spurDone = 1'b0, spurAck = 1'b0, zeroLen = 1'b0;
  int   doneCnt = 0, sdCnt = 0, reqSeen = 0, rdSeen = 0, protoErr = 0;
  bit   prevValid = 1'b0;
  logic [23:0] lastAddr = '0;

  // Arbiter and SDRAM glue hold their strobe until the DUT drops the request.
  assign iSched_Ack = (oSched_Req && (reqCnt >= ackDelay)) || spurAck;
  assign iRd_Done   = (oRd_Req && (rdCnt >= rdDelay)) || spurDone;
  assign iRd_Data   = oRd_Addr[15:0] ^ 16'hA5C3;

  always @(posedge clk) begin
    reqCnt <= oSched_Req ? reqCnt + 1 : 0;
    rdCnt  <= oRd_Req ? rdCnt + 1 : 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (en) begin
        if (oRd_Req && iRd_Done) lastAddr = oRd_Addr;
        if (oData_Valid) begin
          check("valid_expected", 64'(expQ.size() != 0), 64'd1);
          if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            check("word_idx", 64'(oData_Idx), 64'(e.idx));
            check("word_data", 64'(oData), 64'(e.data));
            check("word_addr", 64'(lastAddr), 64'(e.addr));
          end
        end
        if (oDone) begin
          doneCnt++;
          if (!zeroLen && !prevValid) protoErr++;
        end
        if (oSched_Done) begin
          sdCnt++;
          if (!oDone) protoErr++;
        end
        prevValid = oData_Valid;
      end
      if (oSched_Req) reqSeen++;
      if (oRd_Req) rdSeen++;
      if (oSched_Req && oRd_Req) protoErr++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pushWords(input logic [23:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.addr = base + 24'(i);
      e.data = e.addr[15:0] ^ 16'hA5C3;
      e.idx  = 11'(i);
      expQ.push_back(e);
    end
  endtask

  task automatic waitRdReq();
    for (int k = 0; k < 100 && !oRd_Req; k++) step();
    check("rd_req_seen", 64'(oRd_Req), 64'd1);
  endtask

  task automatic waitValid();
    for (int k = 0; k < 100 && !oData_Valid; k++) step();
    check("valid_seen", 64'(oData_Valid), 64'd1);
  endtask

  // mode 0: plain run, 1: spurious strobes, 2: enable freezes
  task automatic runTransfer(input logic [23:0] base, input logic [10:0] len,
                             input int aD, input int rD, input int mode);
    int d0, s0;
    ackDelay = aD;
    rdDelay  = rD;
    zeroLen  = (len == 0);
    d0 = doneCnt;
    s0 = sdCnt;
    reqSeen = 0;
    rdSeen  = 0;
    pushWords(base, int'(len));
    iBase_Addr = base;
    iLen       = len;
    iStart     = 1'b1;
    step();
    iStart = 1'b0;
    if (len == 0) begin
      check("zero_done_high", 64'(oDone), 64'd1);
      step();
      check("zero_done_low", 64'(oDone), 64'd0);
    end
    if (mode == 1) begin
      spurDone = 1'b1;
      step();
      spurDone = 1'b0;
      waitRdReq();
      spurAck    = 1'b1;
      iStart     = 1'b1;
      iBase_Addr = 24'h777777;
      iLen       = 11'd5;
      step();
      spurAck = 1'b0;
      iStart  = 1'b0;
      waitValid();
      spurDone = 1'b1;
      step();
      spurDone = 1'b0;
    end
    if (mode == 2) begin
      waitRdReq();
      en = 1'b0;
      repeat (5) step();
      check("freeze_rd", {oRd_Req, oRd_Addr, oBusy, oData_Valid}, {1'b1, base, 1'b1, 1'b0});
      en = 1'b1;
      waitValid();
      en = 1'b0;
      repeat (5) step();
      check("freeze_valid", {oData_Valid, oData_Idx, oData, oRd_Req},
            {1'b1, 11'd0, base[15:0] ^ 16'hA5C3, 1'b0});
      en = 1'b1;
    end
    for (int k = 0; k < 400 && doneCnt == d0; k++) step();
    step();
    check("done_count", 64'(doneCnt - d0), 64'd1);
    check("sched_done_count", 64'(sdCnt - s0), (len != 0) ? 64'd1 : 64'd0);
    check("words_left", 64'(expQ.size()), 64'd0);
    if (len == 0) check("zero_no_traffic", 64'(reqSeen + rdSeen), 64'd0);
    check("idle_after_run", {oBusy, oSched_Req, oRd_Req}, 64'd0);
  endtask

  initial begin
    int s0;
    rst_n = 1'b0; en = 1'b1; iStart = 1'b0; iBase_Addr = '0; iLen = '0;
    step();
    step();
    check("reset_state", {oSched_Req, oSched_Done, oRd_Req, oRd_Addr, oData_Valid,
                          oData, oData_Idx, oBusy, oDone}, 64'd0);
    rst_n = 1'b1;
    step();

    runTransfer(24'h000100, 11'd4, 3, 2, 0);
    runTransfer(24'hFFFFFE, 11'd3, 1, 1, 0);
    runTransfer(24'h123456, 11'd0, 0, 0, 0);
    runTransfer(24'h000200, 11'd4, 3, 2, 1);
    runTransfer(24'h000500, 11'd3, 2, 2, 2);

    // Reset in the middle of word 2 of an 8-word run.
    ackDelay = 1;
    rdDelay  = 1;
    zeroLen  = 1'b0;
    s0 = sdCnt;
    pushWords(24'h000300, 8);
    iBase_Addr = 24'h000300;
    iLen       = 11'd8;
    iStart     = 1'b1;
    step();
    iStart = 1'b0;
    waitValid();
    waitRdReq();
    rst_n = 1'b0;
    step();
    check("midrun_reset", {oSched_Req, oSched_Done, oRd_Req, oRd_Addr, oData_Valid,
                           oData, oData_Idx, oBusy, oDone}, 64'd0);
    rst_n = 1'b1;
    check("midrun_words_left", 64'(expQ.size()), 64'd7);
    expQ.delete();
    step();
    check("midrun_no_sched_done", 64'(sdCnt - s0), 64'd0);
    runTransfer(24'h000400, 11'd2, 0, 0, 0);

    check("protocol_errors", 64'(protoErr), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
